ppm_decoder_multi: RTL and testbench
====================================

Name: ppm_decoder_multi

Overview:
Parametrised PPM receiver decoder, successor to the fixed 8-channel PPM capture. It adds configurable channel count, input synchronisation, a glitch filter, pulse-range validation, whole-frame atomic commit, loss-of-signal failsafe, and error/frame counters. It runs entirely on the bus clock and uses a tick enable for timing. It sits between the RC receiver pin and the register file, which reads channels through the registered read port or the flat bus.

Parameters:
NUM_CH, 8, channels per frame (1..16)
CNT_W, 16, interval counter and channel value width
SYNC_MIN, 3000, interval strictly greater than this (ticks) is a sync gap
PULSE_MIN, 800, minimum valid channel interval (inclusive)
PULSE_MAX, 2200, maximum valid channel interval (inclusive)
FILT_TICKS, 2, glitch filter length in ticks; 0 = bypass
LOST_TICKS, 50000, ticks without a committed frame before failsafe
SEL_W, 4, width of rd_sel

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, asynchronous, active-high
tick_i  in  1  one-cycle timing enable (nominally 1 MHz); all timing counts in ticks
ppm_in  in  1  raw asynchronous PPM input, idle high
rd_sel  in  SEL_W  channel select for read port
rd_dat  out  CNT_W  registered channel value for rd_sel
ch_flat  out  NUM_CH*CNT_W  committed channels; channel 0 in LSBs
frame_stb  out  1  one-cycle pulse when a frame commits
frame_cnt  out  8  committed frame count, wraps mod 256
err_cnt  out  8  frame error count, saturates at 255
lost  out  1  failsafe flag

Behaviour:
- Reset (async, immediate): ch_flat=0, rd_dat=0, frame_stb=0, frame_cnt=0, err_cnt=0, lost=1. Internal state: FSM=HUNT, ch_idx=0, sync FFs=1, filtered level=1, interval counter=0, timeout counter=0. A reset mid-frame discards any partial frame.
- Synchroniser: 2 FFs on wb_clk_i.
- Glitch filter:
  - The filtered level takes the synchronised value only after they differ on FILT_TICKS consecutive ticks.
  - A mismatch count resets whenever the values agree.
  - With FILT_TICKS=0, filtered equals the synchronised value.
- Edge: an event occurs in the cycle the filtered level goes 0->1. Only rising edges are timed.
- Interval counter:
  - Increments on tick_i and saturates at 2^CNT_W-1.
  - On an edge, interval = current count, and the counter loads 0 in the same cycle (any coincident tick is dropped).
- Classification on an edge:
  - SYNC if interval > SYNC_MIN (a saturated counter counts as SYNC).
  - Otherwise CH; CH is valid iff PULSE_MIN <= interval <= PULSE_MAX.
- FSM:
  - HUNT: SYNC -> RX, ch_idx=0. CH ignored.
  - RX, SYNC with ch_idx>0: short frame; err_cnt+1, partial data discarded, stay RX, ch_idx=0.
  - RX, SYNC with ch_idx=0: stay RX.
  - RX, valid CH with ch_idx<NUM_CH-1: shadow[ch_idx]=interval, ch_idx+1.
  - RX, valid CH with ch_idx=NUM_CH-1: commit. ch_flat loads shadow[0..NUM_CH-2] plus the current interval on the next edge of wb_clk_i. frame_stb=1 for that one cycle. frame_cnt+1, lost=0, timeout counter=0. Go to WAIT.
  - RX, invalid CH: err_cnt+1, go to HUNT. ch_flat is unchanged.
  - WAIT: extra CH (receiver sends more than NUM_CH channels) is ignored with no error. SYNC -> RX, ch_idx=0.
- Commit is atomic: ch_flat never holds a mix of channels from two different frames.
- Failsafe:
  - The timeout counter increments on tick_i since the last commit and saturates.
  - When it reaches LOST_TICKS: lost=1 and FSM forced to HUNT. ch_flat keeps its last values.
  - If commit and timeout coincide, commit wins.
- Read port: rd_dat <= (rd_sel<NUM_CH) ? channel[rd_sel] : 0, one-cycle latency. It reads ch_flat as it was before any same-cycle commit.
- Edge-to-commit latency from ppm_in: 2 sync cycles, plus FILT_TICKS ticks, plus 1 cycle.

Test Plan:
1. Defaults, tick_i=1. Reset; high/low gap of 5000; 8 edges at intervals 1000,1100,...,1700 -> after the 8th edge, ch_flat = {1700,...,1000} (channel 0 = 1000), frame_stb pulses exactly once, frame_cnt=1, lost=0, err_cnt=0.
2. Valid frame with a 1-tick low glitch inside channel 2 (FILT_TICKS=2) -> no extra edge, channel 2 still 1200, err_cnt=0.
3. Frame with channel 3 interval = 500 -> err_cnt=1, no frame_stb, ch_flat holds the previous frame; the next good frame with values 1500 commits normally. Boundary intervals 800, 2200 and 3000 are accepted as CH; 3001 is treated as SYNC.
4. Five channels then SYNC -> err_cnt+1, no commit. A 10-channel frame -> commit after the 8th edge, channels 9-10 ignored, err_cnt unchanged.
5. ppm_in held high after a commit -> lost rises exactly LOST_TICKS ticks after the commit; ch_flat retained; the next valid frame clears lost.
6. Assert wb_rst_i mid-frame -> all outputs return to reset values immediately, without waiting for a clock. After release, rd_sel=2 gives 0; rd_sel=9 gives 0 with one-cycle latency after a later commit.

Source files
------------

// File: rtl/ppm_decoder_multi.sv
// Parametrised PPM decoder: synchronise and glitch-filter the input, time rising edges in ticks,
// validate each channel and commit complete frames atomically, with loss-of-signal failsafe.
module ppm_decoder_multi #(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 16,
  parameter int SYNC_MIN   = 3000,
  parameter int PULSE_MIN  = 800,
  parameter int PULSE_MAX  = 2200,
  parameter int FILT_TICKS = 2,
  parameter int LOST_TICKS = 50000,
  parameter int SEL_W      = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    tick_i,
  input  logic                    ppm_in,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [CNT_W-1:0]        rd_dat,
  output logic [NUM_CH*CNT_W-1:0] ch_flat,
  output logic                    frame_stb,
  output logic [7:0]              frame_cnt,
  output logic [7:0]              err_cnt,
  output logic                    lost
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W  = $clog2(LOST_TICKS + 1);
  localparam int FC_W  = (FILT_TICKS > 1) ? $clog2(FILT_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(LOST_TICKS);

  typedef enum logic [1:0] {S_HUNT, S_RX, S_WAIT} state_t;

  logic                    r_sync1, r_sync2;
  logic                    r_filt, w_filt_nxt;
  logic [FC_W-1:0]         r_fcnt, w_fcnt_nxt;
  logic                    w_edge, w_is_sync, w_valid, w_commit, w_to_fire;
  logic [CNT_W-1:0]        r_ivl;
  logic [TO_W-1:0]         r_to;
  logic [IDX_W-1:0]        r_idx;
  state_t                  r_state;
  logic [CNT_W-1:0]        r_shadow [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] r_ch_flat;
  logic [CNT_W-1:0]        r_rd_dat, w_rd_nxt;
  logic                    r_frame_stb, r_lost;
  logic [7:0]              r_frame_cnt, r_err_cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ppm_in;
      r_sync2 <= r_sync1;
    end
  end

  // Filtered level follows the synchroniser only after FILT_TICKS consecutive disagreeing ticks.
  always_comb begin
    w_filt_nxt = r_filt;
    w_fcnt_nxt = r_fcnt;
    if (FILT_TICKS == 0) begin
      w_filt_nxt = r_sync2;
    end else if (r_sync2 == r_filt) begin
      w_fcnt_nxt = '0;
    end else if (tick_i) begin
      if (r_fcnt == FC_W'(FILT_TICKS - 1)) begin
        w_filt_nxt = r_sync2;
        w_fcnt_nxt = '0;
      end else begin
        w_fcnt_nxt = r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else begin
      r_filt <= w_filt_nxt;
      r_fcnt <= w_fcnt_nxt;
    end
  end

  assign w_edge    = w_filt_nxt & ~r_filt;
  assign w_is_sync = (r_ivl > CNT_W'(SYNC_MIN)) || (r_ivl == CNT_MAX);
  assign w_valid   = (r_ivl >= CNT_W'(PULSE_MIN)) && (r_ivl <= CNT_W'(PULSE_MAX));
  assign w_commit  = w_edge && !w_is_sync && w_valid && (r_state == S_RX) &&
                     (r_idx == IDX_W'(NUM_CH - 1));
  assign w_to_fire = tick_i && (r_to == TO_W'(LOST_TICKS - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ivl <= '0;
    end else if (w_edge) begin
      r_ivl <= '0;
    end else if (tick_i && (r_ivl != CNT_MAX)) begin
      r_ivl <= r_ivl + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_HUNT;
      r_idx       <= '0;
      r_to        <= '0;
      r_ch_flat   <= '0;
      r_frame_stb <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_lost      <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
    end else begin
      r_frame_stb <= 1'b0;
      if (tick_i && (r_to != TO_LIM)) r_to <= r_to + 1'b1;
      if (w_edge) begin
        case (r_state)
          S_HUNT: begin
            if (w_is_sync) begin
              r_state <= S_RX;
              r_idx   <= '0;
            end
          end
          S_RX: begin
            if (w_is_sync) begin
              if ((r_idx != '0) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
              r_idx <= '0;
            end else if (!w_valid) begin
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_state <= S_HUNT;
              r_idx   <= '0;
            end else if (w_commit) begin
              // Whole frame lands in one clock so readers never see a mix of two frames.
              for (int i = 0; i < NUM_CH - 1; i++) r_ch_flat[i*CNT_W +: CNT_W] <= r_shadow[i];
              r_ch_flat[(NUM_CH-1)*CNT_W +: CNT_W] <= r_ivl;
              r_frame_stb <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_lost      <= 1'b0;
              r_to        <= '0;
              r_state     <= S_WAIT;
              r_idx       <= '0;
            end else begin
              r_shadow[r_idx] <= r_ivl;
              r_idx           <= r_idx + 1'b1;
            end
          end
          S_WAIT: begin
            if (w_is_sync) begin
              r_state <= S_RX;
              r_idx   <= '0;
            end
          end
          default: begin
            r_state <= S_HUNT;
            r_idx   <= '0;
          end
        endcase
      end
      if (w_to_fire && !w_commit) begin
        r_lost  <= 1'b1;
        r_state <= S_HUNT;
        r_idx   <= '0;
      end
    end
  end

  // Read mux sees the pre-commit bank, so a same-cycle commit shows up one read later.
  always_comb begin
    w_rd_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) w_rd_nxt = r_ch_flat[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_rd_dat <= '0;
    else          r_rd_dat <= w_rd_nxt;
  end

  assign rd_dat    = r_rd_dat;
  assign ch_flat   = r_ch_flat;
  assign frame_stb = r_frame_stb;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
  assign lost      = r_lost;

endmodule

// File: tb/tb_ppm_decoder_multi.sv
// Randomised and directed bench for ppm_decoder_multi with a frame-level reference model and scoreboard.
module tb_ppm_decoder_multi;

  localparam int NUM_CH = 8, CNT_W = 16, SYNC_MIN = 300, PULSE_MIN = 80, PULSE_MAX = 220;
  localparam int FILT_TICKS = 2, LOST_TICKS = 4000, SEL_W = 4;
  localparam int FW = NUM_CH * CNT_W;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b1, ppm = 1'b1;
  logic [SEL_W-1:0] rd_sel = '0;
  logic [CNT_W-1:0] rd_dat;
  logic [FW-1:0]    ch_flat;
  logic             frame_stb, lost;
  logic [7:0]       frame_cnt, err_cnt;

  ppm_decoder_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_MIN(SYNC_MIN), .PULSE_MIN(PULSE_MIN),
    .PULSE_MAX(PULSE_MAX), .FILT_TICKS(FILT_TICKS), .LOST_TICKS(LOST_TICKS), .SEL_W(SEL_W)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .tick_i(tick), .ppm_in(ppm), .rd_sel(rd_sel),
    .rd_dat(rd_dat), .ch_flat(ch_flat), .frame_stb(frame_stb), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt), .lost(lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: works on whole intervals (in ticks) and frame-level bookkeeping.
  typedef struct { logic [FW-1:0] flat; int fcnt; int ecnt; } exp_t;
  exp_t sb[$];
  bit   m_hunt, m_wait, m_fired, m_lost;
  int   m_part[$];
  int   m_ch[NUM_CH];
  int   m_frames, m_errs, m_last_t;

  function automatic logic [FW-1:0] pack_ch();
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_ch[i]);
    return r;
  endfunction

  function automatic void model_reset(input int t);
    m_hunt = 1; m_wait = 0; m_fired = 0; m_lost = 1;
    m_part.delete();
    foreach (m_ch[i]) m_ch[i] = 0;
    m_frames = 0; m_errs = 0; m_last_t = t;
    sb.delete();
  endfunction

  function automatic void m_err();
    if (m_errs < 255) m_errs++;
  endfunction

  function automatic void m_force();
    m_lost = 1; m_fired = 1; m_hunt = 1; m_wait = 0;
    m_part.delete();
  endfunction

  function automatic void model_edge(input int v, input int t);
    bit committed;
    committed = 0;
    if (!m_fired && (t > m_last_t + LOST_TICKS)) m_force();
    if (v > SYNC_MIN) begin
      if (!m_hunt && !m_wait && (m_part.size() > 0)) m_err();
      m_hunt = 0; m_wait = 0;
      m_part.delete();
    end else if (!m_hunt && !m_wait) begin
      if ((v < PULSE_MIN) || (v > PULSE_MAX)) begin
        m_err();
        m_hunt = 1;
        m_part.delete();
      end else begin
        m_part.push_back(v);
        if (m_part.size() == NUM_CH) begin
          foreach (m_ch[i]) m_ch[i] = m_part[i];
          m_frames = (m_frames + 1) % 256;
          m_lost = 0; m_fired = 0; m_last_t = t; m_wait = 1; committed = 1;
          m_part.delete();
          sb.push_back('{pack_ch(), m_frames, m_errs});
        end
      end
    end
    if (!committed && !m_fired && (t == m_last_t + LOST_TICKS)) m_force();
  endfunction

  // Stimulus: rising edges placed so that v ticks elapse between the DUT's timed edges.
  int last_rise = 0;

  task automatic goto_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_edge(input int v, input bit glitch);
    int rise, low;
    rise = last_rise + v + 1;
    low  = $urandom_range(30, 15);
    if (glitch) begin
      goto_cyc(last_rise + (v - low) / 2);
      ppm = 1'b0;
      goto_cyc(last_rise + (v - low) / 2 + 1);
      ppm = 1'b1;
    end
    goto_cyc(rise - low);
    ppm = 1'b0;
    goto_cyc(rise);
    ppm = 1'b1;
    model_edge(v, rise);
    last_rise = rise;
  endtask

  task automatic send_list(input int vals[$], input int g);
    foreach (vals[i]) send_edge(vals[i], i == g);
  endtask

  task automatic checkpoint(input string tag);
    goto_cyc(last_rise + 10);
    chk({tag, ":err_cnt"},   FW'(err_cnt),   FW'(m_errs));
    chk({tag, ":frame_cnt"}, FW'(frame_cnt), FW'(m_frames));
    chk({tag, ":pending"},   FW'(sb.size()), FW'(0));
    chk({tag, ":ch_flat"},   ch_flat,        pack_ch());
  endtask

  task automatic rd_sweep();
    int e;
    for (int s = 0; s < 16; s++) begin
      rd_sel = SEL_W'(s);
      @(posedge clk); #1;
      e = 0;
      if (s < NUM_CH) e = m_ch[s];
      chk("rd_dat", FW'(rd_dat), FW'(e));
    end
  endtask

  task automatic wait_stb(output int c);
    c = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (frame_stb) begin
        c = cyc;
        break;
      end
    end
    n_checks++;
    if (c < 0) begin
      n_fail++;
      $display("FAIL wait_stb: frame_stb absent for 40 cycles, required a pulse");
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ":ch_flat"},   ch_flat,          FW'(0));
    chk({tag, ":rd_dat"},    FW'(rd_dat),      FW'(0));
    chk({tag, ":frame_stb"}, FW'(frame_stb),   FW'(0));
    chk({tag, ":frame_cnt"}, FW'(frame_cnt),   FW'(0));
    chk({tag, ":err_cnt"},   FW'(err_cnt),     FW'(0));
    chk({tag, ":lost"},      FW'(lost),        FW'(1));
  endtask

  // Monitor: every commit pops the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && frame_stb) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_stb: unexpected commit with frame_cnt %0d, required none", frame_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit:ch_flat",   ch_flat,        e.flat);
        chk("commit:frame_cnt", FW'(frame_cnt), FW'(e.fcnt));
        chk("commit:err_cnt",   FW'(err_cnt),   FW'(e.ecnt));
        chk("commit:lost",      FW'(lost),      FW'(0));
      end
    end
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int q[$];
    int c0, c1, n, v, r;
    model_reset(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    model_reset(cyc);
    last_rise = cyc;

    // Basic frame, then a filtered glitch inside channel 2
    send_edge(500, 0);
    q = '{100, 110, 120, 130, 140, 150, 160, 170};
    send_list(q, -1);
    checkpoint("basic");
    rd_sweep();
    send_edge(500, 0);
    send_list(q, 2);
    checkpoint("glitch");

    // Too-short channel, recovery, and range boundaries
    send_edge(500, 0);
    q = '{100, 100, 100, 50, 100, 100, 100, 100};
    send_list(q, -1);
    checkpoint("short_pulse");
    send_edge(500, 0);
    q = '{150, 150, 150, 150, 150, 150, 150, 150};
    send_list(q, -1);
    checkpoint("recover");
    send_edge(500, 0);
    q = '{80, 220, 80, 220, 100, 101, 102, 103};
    send_list(q, -1);
    checkpoint("bounds");
    send_edge(500, 0);
    q = '{100, 300, 100};
    send_list(q, -1);
    checkpoint("ch_300");
    send_edge(500, 0);
    q = '{100, 100, 301, 90, 91, 92, 93, 94, 95, 96, 97};
    send_list(q, -1);
    checkpoint("sync_301");

    // Short frame, then an over-long frame
    send_edge(500, 0);
    q = '{120, 121, 122, 123, 124};
    send_list(q, -1);
    send_edge(500, 0);
    q = '{200, 190, 180, 170, 160, 150, 140, 130, 60, 250};
    send_list(q, -1);
    checkpoint("long_frame");

    // Loss of signal after a commit, then recovery
    send_edge(500, 0);
    q = '{111, 112, 113, 114, 115, 116, 117, 118};
    send_list(q, -1);
    wait_stb(c0);
    fork
      send_edge(LOST_TICKS + 700, 0);
      begin
        c1 = -1;
        for (int k = 0; k < LOST_TICKS + 200; k++) begin
          @(posedge clk); #1;
          if (lost) begin
            c1 = cyc;
            break;
          end
        end
        chk("lost_delay",   FW'(c1 - c0), FW'(LOST_TICKS));
        chk("lost_hold_ch", ch_flat,      pack_ch());
      end
    join
    q = '{210, 200, 190, 180, 170, 160, 150, 140};
    send_list(q, -1);
    checkpoint("relock");
    chk("relock:lost", FW'(lost), FW'(0));

    // Randomised frames: mixed lengths, out-of-range and boundary values, glitches
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(10, 5);
      send_edge($urandom_range(600, 320), 0);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(99, 0);
        if (r < 8)       v = $urandom_range(79, 60);
        else if (r < 16) v = $urandom_range(290, 221);
        else if (r < 22) v = (r % 2 == 1) ? PULSE_MIN : PULSE_MAX;
        else             v = $urandom_range(PULSE_MAX, PULSE_MIN);
        send_edge(v, $urandom_range(3, 0) == 0);
      end
      checkpoint("rand");
    end

    // Asynchronous reset in the middle of a frame
    send_edge(500, 0);
    q = '{100, 120, 140};
    send_list(q, -1);
    goto_cyc(last_rise + 50);
    #3;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    ppm = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset(cyc);
    last_rise = cyc;
    rd_sweep();
    send_edge(500, 0);
    q = '{81, 99, 133, 150, 177, 199, 210, 219};
    send_list(q, -1);
    checkpoint("post_rst");
    rd_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
